ram_fifo_fwft_ctrl: RTL

FIFO control stage that sits directly upstream of the generic dual-port RAM primitive (port A: write with read-back, port B: read-only, both with 1-cycle registered read data). It accepts a valid/ready input stream and writes it into the RAM through port A. It reads the RAM through port B and presents a first-word-fall-through valid/ready output stream. A 2-entry output queue hides the RAM read latency, so sustained throughput is one word per clock in both directions.

---
 rtl/ram_fifo_fwft_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/ram_fifo_fwft_ctrl.sv
// First-word-fall-through FIFO controller in front of a dual-port RAM with registered
// read data; a 2-entry output queue hides the RAM read latency so both sides stream at full rate.
module ram_fifo_fwft_ctrl #(
   parameter int DEPTH      = 2048,
   parameter int WIDTH      = 8,
   parameter int DEPTH_BITS = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [DEPTH_BITS+1:0] level,
   output logic [DEPTH_BITS-1:0] ram_address_a,
   output logic                  ram_wren_a,
   output logic [WIDTH-1:0]      ram_data_a,
   output logic [DEPTH_BITS-1:0] ram_address_b,
   input  logic [WIDTH-1:0]      ram_q_b
);

   localparam logic [DEPTH_BITS:0] RAM_FULL = (DEPTH_BITS+1)'(DEPTH);

   logic [DEPTH_BITS-1:0]     wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS-1:0]     rd_ptr_q, rd_ptr_d;
   logic [DEPTH_BITS:0]       ram_count_q, ram_count_d;
   logic                      inflight_q, inflight_d;
   logic [1:0][WIDTH-1:0]     outq_q, outq_d;
   logic [1:0]                outq_cnt_q, outq_cnt_d;
   logic [DEPTH_BITS+1:0]     level_q, level_d;

   logic                      push, pop, issue;
   logic [1:0]                occ, cnt_after;

   assign in_ready      = reset_n && (ram_count_q < RAM_FULL);
   assign push          = in_valid && in_ready;
   assign out_valid     = (outq_cnt_q != 2'd0);
   assign pop           = out_valid && out_ready;
   assign out_data      = outq_q[0];
   assign level         = level_q;

   assign ram_address_a = wr_ptr_q;
   assign ram_wren_a    = push;
   assign ram_data_a    = in_data;
   assign ram_address_b = rd_ptr_q;

   // Reserve an outq slot for every read in flight so the queue can never overflow.
   assign occ       = outq_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
   assign issue     = (ram_count_q != '0) && (occ < 2'd2);
   assign cnt_after = outq_cnt_q - {1'b0, pop};

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      ram_count_d = ram_count_q;
      inflight_d  = issue;
      outq_d      = outq_q;
      outq_cnt_d  = cnt_after + {1'b0, inflight_q};
      level_d     = level_q + (DEPTH_BITS+2)'(push) - (DEPTH_BITS+2)'(pop);

      if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, issue})
         2'b10:   ram_count_d = ram_count_q + 1'b1;
         2'b01:   ram_count_d = ram_count_q - 1'b1;
         default: ram_count_d = ram_count_q;
      endcase

      if (pop) outq_d[0] = outq_q[1];
      // With a read in flight at most one entry remains after the pop.
      if (inflight_q) outq_d[cnt_after[0]] = ram_q_b;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ram_count_q <= '0;
         inflight_q  <= 1'b0;
         outq_q      <= '0;
         outq_cnt_q  <= '0;
         level_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ram_count_q <= ram_count_d;
         inflight_q  <= inflight_d;
         outq_q      <= outq_d;
         outq_cnt_q  <= outq_cnt_d;
         level_q     <= level_d;
      end
   end

endmodule
